spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_regfile.sv | 36 +++
 rtl/spi_cmd_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        ERROR
    } state_t;

    localparam int unsigned REG_COUNT    = 16;
    localparam logic [3:0]  STATUS_ADDR  = 4'hF;
    localparam int unsigned CMD_READ_BIT = 7;
    localparam logic [7:0]  RSVD_MASK    = 8'h70;

endpackage

// File: rtl/spi_regfile.sv
// 15 x 8 writable register file; address 15 is not stored (status lives there).
module spi_regfile
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata,
    output logic [7:0] reg0
);

    logic [7:0] regs [REG_COUNT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != STATUS_ADDR)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (raddr != STATUS_ADDR) begin
            rdata = regs[raddr];
        end
    end

    assign reg0 = regs[0];

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: first byte of a frame selects read/write and start
// address; subsequent bytes stream through an auto-incrementing pointer.
module spi_cmd_ctrl
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    input  logic [6:0] ro_status,
    output logic [7:0] ctrl_out,
    output logic       err_led,
    output logic       busy
);

    state_t     state, state_nxt;
    logic [3:0] addr_ptr, addr_nxt;
    logic [7:0] tx_nxt;
    logic       load_pend, load_nxt;
    logic       err_nxt;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] rd_val;

    spi_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (addr_ptr),
        .wdata (rx_byte),
        .raddr (addr_ptr),
        .rdata (rdata),
        .reg0  (ctrl_out)
    );

    assign rd_val = (addr_ptr == STATUS_ADDR) ? {err_led, ro_status} : rdata;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_ptr  <= '0;
            tx_byte   <= '0;
            load_pend <= 1'b0;
            err_led   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_ptr  <= addr_nxt;
            tx_byte   <= tx_nxt;
            load_pend <= load_nxt;
            err_led   <= err_nxt;
        end
    end

    // load_pend delays the tx_byte fetch one cycle behind each pointer update
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_ptr;
        tx_nxt    = tx_byte;
        load_nxt  = 1'b0;
        err_nxt   = err_led;
        we        = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = '0;
                if (frame_active) state_nxt = CMD;
            end
            CMD: begin
                tx_nxt = '0;
                if (!frame_active) begin
                    state_nxt = IDLE;
                end else if (rx_valid) begin
                    if ((rx_byte & RSVD_MASK) != '0) begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                        tx_nxt    = 8'hFF;
                    end else begin
                        addr_nxt = rx_byte[3:0];
                        if (rx_byte[CMD_READ_BIT]) begin
                            state_nxt = READ;
                            load_nxt  = 1'b1;
                        end else begin
                            state_nxt = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                tx_nxt = '0;
                if (!frame_active) begin
                    state_nxt = IDLE;
                end else if (rx_valid) begin
                    we       = 1'b1;
                    addr_nxt = addr_ptr + 4'd1;
                end
            end
            READ: begin
                if (!frame_active) begin
                    state_nxt = IDLE;
                    tx_nxt    = '0;
                end else begin
                    if (load_pend) tx_nxt = rd_val;
                    if (tx_ready) begin
                        addr_nxt = addr_ptr + 4'd1;
                        load_nxt = 1'b1;
                    end
                end
            end
            ERROR: begin
                tx_nxt = 8'hFF;
                if (!frame_active) begin
                    state_nxt = IDLE;
                    tx_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT ports.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_byte;
    logic [6:0] ro_status = '0;
    logic [7:0] ctrl_out;
    logic       err_led;
    logic       busy;

    spi_cmd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_ready     (tx_ready),
        .tx_byte      (tx_byte),
        .ro_status    (ro_status),
        .ctrl_out     (ctrl_out),
        .err_led      (err_led),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    localparam int unsigned S_TX   = 0;
    localparam int unsigned S_CTRL = 1;
    localparam int unsigned S_ERR  = 2;
    localparam int unsigned S_BUSY = 3;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [7:0]  val;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  act;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                S_TX:    act = tx_byte;
                S_CTRL:  act = ctrl_out;
                S_ERR:   act = {7'd0, err_led};
                default: act = {7'd0, busy};
            endcase
            vectors++;
            if (act !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic chk(input string nm, input int unsigned sel, input logic [7:0] v);
        exp_t x;
        x.name = nm;
        x.sel  = sel;
        x.val  = v;
        x.due  = cyc;
        sb.push_back(x);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        cycle();
        rx_valid = 1'b0;
    endtask

    task automatic next_byte();
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        cycle();
    endtask

    task automatic start_frame();
        frame_active = 1'b1;
        cycle();
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        cycle();
        cycle();
        chk("reset_tx", S_TX, 8'h00);
        chk("reset_ctrl", S_CTRL, 8'h00);
        chk("reset_err", S_ERR, 8'h00);
        chk("reset_busy", S_BUSY, 8'h00);
        cycle();
        rst = 1'b0;
        cycle();

        // Write frame: reg2=AA, reg3=BB
        start_frame();
        chk("cmd_busy", S_BUSY, 8'h01);
        send_byte(8'h02);
        chk("write_tx_zero", S_TX, 8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        end_frame();
        chk("wr_end_busy", S_BUSY, 8'h00);
        chk("wr_end_tx", S_TX, 8'h00);

        // Empty frame: no error
        start_frame();
        end_frame();
        chk("empty_err", S_ERR, 8'h00);
        chk("empty_busy", S_BUSY, 8'h00);

        // Read frame from reg2
        start_frame();
        send_byte(8'h82);
        cycle();
        chk("rd_reg2", S_TX, 8'hAA);
        next_byte();
        chk("rd_reg3", S_TX, 8'hBB);
        next_byte();
        chk("rd_reg4", S_TX, 8'h00);
        end_frame();
        chk("rd_end_tx", S_TX, 8'h00);

        // Wrap through read-only address 15 into reg0
        start_frame();
        send_byte(8'h0E);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("wrap_ctrl", S_CTRL, 8'h33);
        end_frame();
        ro_status = 7'h2A;
        start_frame();
        send_byte(8'h8E);
        cycle();
        chk("rd_reg14", S_TX, 8'h11);
        next_byte();
        chk("rd_status", S_TX, 8'h2A);
        next_byte();
        chk("rd_wrap_reg0", S_TX, 8'h33);
        end_frame();

        // Reserved bits set -> error
        start_frame();
        send_byte(8'h40);
        chk("err_led", S_ERR, 8'h01);
        chk("err_tx", S_TX, 8'hFF);
        send_byte(8'h55);
        next_byte();
        chk("err_tx_hold", S_TX, 8'hFF);
        chk("err_busy", S_BUSY, 8'h01);
        end_frame();
        chk("err_end_tx", S_TX, 8'h00);
        chk("err_sticky", S_ERR, 8'h01);
        ro_status = 7'h05;
        start_frame();
        send_byte(8'h8F);
        cycle();
        chk("rd_status_err", S_TX, 8'h85);
        next_byte();
        chk("err_no_write", S_TX, 8'h33);
        end_frame();
        chk("err_ctrl_kept", S_CTRL, 8'h33);

        // Frame end on same cycle as data byte drops it
        start_frame();
        send_byte(8'h05);
        send_byte(8'h66);
        end_frame();
        start_frame();
        send_byte(8'h05);
        frame_active = 1'b0;
        rx_valid     = 1'b1;
        rx_byte      = 8'h77;
        cycle();
        rx_valid = 1'b0;
        chk("drop_busy", S_BUSY, 8'h00);
        cycle();
        start_frame();
        send_byte(8'h85);
        cycle();
        chk("drop_reg5", S_TX, 8'h66);
        end_frame();

        // Asynchronous reset mid-WRITE, frame stays active
        start_frame();
        send_byte(8'h03);
        send_byte(8'hC3);
        #2;
        rst = 1'b1;
        chk("arst_tx", S_TX, 8'h00);
        chk("arst_ctrl", S_CTRL, 8'h00);
        chk("arst_err", S_ERR, 8'h00);
        chk("arst_busy", S_BUSY, 8'h00);
        cycle();
        rst = 1'b0;
        cycle();
        chk("arst_cmd_busy", S_BUSY, 8'h01);
        send_byte(8'h01);
        send_byte(8'h5A);
        end_frame();
        start_frame();
        send_byte(8'h81);
        cycle();
        chk("arst_rd_reg1", S_TX, 8'h5A);
        next_byte();
        chk("arst_rd_reg2", S_TX, 8'h00);
        next_byte();
        chk("arst_rd_reg3", S_TX, 8'h00);
        end_frame();

        cycle();
        cycle();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
